// File: rtl/div43_pkg.sv
// div43_pkg -- shared constants and FSM encoding for the divide-by-43 sequencer.
//   DIVIDEND_W   : dividend width (30)
//   Q_W / R_W    : reported quotient / remainder widths (21 / 6)
//   DIVISOR      : constant divisor (43)
//   ROUND_THRESH : remainder at or above which rounding bumps the quotient (22)
//   CNT_W        : iteration counter width (5, counts 0..29)
//   PR_W         : partial remainder width (7, holds up to 2*42+1 before subtract)
package div43_pkg;

  localparam int DIVIDEND_W   = 30;
  localparam int Q_W          = 21;
  localparam int R_W          = 6;
  localparam int DIVISOR      = 43;
  localparam int ROUND_THRESH = 22;
  localparam int CNT_W        = 5;
  localparam int PR_W         = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div43_step.sv
// div43_step -- one combinational restoring-division iteration by 43.
//   rem_in  : current partial remainder (always < 43)
//   bit_in  : next dividend bit, MSB first
//   rem_out : partial remainder after shift and conditional subtract
//   q_bit   : quotient bit produced by this iteration
module div43_step
  import div43_pkg::*;
(
  input  logic [PR_W-1:0] rem_in,
  input  logic            bit_in,
  output logic [PR_W-1:0] rem_out,
  output logic            q_bit
);

  logic [PR_W-1:0] trial;

  always_comb begin
    trial   = {rem_in[PR_W-2:0], bit_in};
    rem_out = trial;
    q_bit   = 1'b0;
    if (trial >= PR_W'(DIVISOR)) begin
      rem_out = trial - PR_W'(DIVISOR);
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/divide_by_43_seq.sv
// divide_by_43_seq -- sequential unsigned divide by 43, one quotient bit per clock.
//   clk, rst_n          : clock, async active-low reset
//   x_in, in_valid      : dividend and its valid; accepted in IDLE (in_ready=1)
//   q_out, r_out, ovf   : low 21 quotient bits, remainder, quotient overflow
//   out_valid/out_ready : result handshake, held in DONE until out_ready
// Optional feature: define DIV43_ROUND_EN to round the quotient to nearest
// (remainder >= 22 bumps it); r_out stays the unrounded remainder.
//
// state | meaning
// IDLE  | waiting for a dividend, in_ready=1
// BUSY  | 30 restoring iterations, counter 0..29
// DONE  | result presented, out_valid=1
module divide_by_43_seq
  import div43_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIVIDEND_W-1:0] x_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [Q_W-1:0]        q_out,
  output logic [R_W-1:0]        r_out,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_t                state, state_nxt;
  logic [DIVIDEND_W-1:0] dividend_r;
  logic [DIVIDEND_W-1:0] quot_r;
  logic [PR_W-1:0]       rem_r;
  logic [CNT_W-1:0]      cnt_r;

  logic [PR_W-1:0]       step_rem;
  logic                  step_q;
  logic [DIVIDEND_W-1:0] quot_full;
  logic [DIVIDEND_W-1:0] quot_fin;
  logic                  last_iter;

  div43_step u_step (
    .rem_in  (rem_r),
    .bit_in  (dividend_r[DIVIDEND_W-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign last_iter = (cnt_r == CNT_W'(DIVIDEND_W - 1));
  assign quot_full = {quot_r[DIVIDEND_W-2:0], step_q};

`ifdef DIV43_ROUND_EN
  // Largest quotient is well under 2^29, so the increment cannot wrap.
  assign quot_fin = quot_full + DIVIDEND_W'(step_rem >= PR_W'(ROUND_THRESH));
`else
  assign quot_fin = quot_full;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_r <= '0;
      quot_r     <= '0;
      rem_r      <= '0;
      cnt_r      <= '0;
      q_out      <= '0;
      r_out      <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dividend_r <= x_in;
            quot_r     <= '0;
            rem_r      <= '0;
            cnt_r      <= '0;
          end
        end
        BUSY: begin
          // Dividend register doubles as the MSB-first bit shifter.
          dividend_r <= {dividend_r[DIVIDEND_W-2:0], 1'b0};
          quot_r     <= quot_full;
          rem_r      <= step_rem;
          cnt_r      <= cnt_r + 1'b1;
          if (last_iter) begin
            q_out <= quot_fin[Q_W-1:0];
            r_out <= step_rem[R_W-1:0];
            ovf   <= |quot_fin[DIVIDEND_W-1:Q_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_by_43_seq.sv
// tb_divide_by_43_seq -- directed and randomized checks for divide_by_43_seq.
// Build with DIV43_ROUND_EN defined to exercise the rounding variant.
module tb_divide_by_43_seq;

  logic        clk;
  logic        rst_n;
  logic [29:0] x_in;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] q_out;
  logic [5:0]  r_out;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  divide_by_43_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_out     (q_out),
    .r_out     (r_out),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] x;
    logic [20:0] q;
    logic [5:0]  r;
    logic        o;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic void model(input logic [29:0] x, output logic [20:0] q,
                                output logic [5:0] r, output logic o);
    int unsigned qf;
    int unsigned rf;
    qf = 32'(x) / 43;
    rf = 32'(x) % 43;
`ifdef DIV43_ROUND_EN
    if (rf >= 22) qf = qf + 1;
`endif
    o = (qf > 32'd2097151);
    q = qf[20:0];
    r = rf[5:0];
  endfunction

  task automatic send(input logic [29:0] x);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    x_in     = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    send(v.x);
    wait_done(lat);
    chk("latency", 32'(lat), 32'd30);
    chk("q_out", 32'(q_out), 32'(v.q));
    chk("r_out", 32'(r_out), 32'(v.r));
    chk("ovf", 32'(ovf), 32'(v.o));
    handshake();
  endtask

  initial begin
    int lat;
    logic [29:0] xr;
    logic [20:0] qe;
    logic [5:0]  re;
    logic        oe;

    rst_n     = 1'b0;
    x_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q_out", 32'(q_out), 32'd0);
    chk("rst_r_out", 32'(r_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    vecs.push_back('{30'd430,        21'd10,      6'd0,  1'b0});
    vecs.push_back('{30'd43,         21'd1,       6'd0,  1'b0});
    vecs.push_back('{30'd0,          21'd0,       6'd0,  1'b0});
    vecs.push_back('{30'd90177493,   21'd2097151, 6'd0,  1'b0});
    vecs.push_back('{30'd90177536,   21'd0,       6'd0,  1'b1});
    vecs.push_back('{30'd1073741823, 21'd1902068, 6'd3,  1'b1});
    vecs.push_back('{30'd64,         21'd1,       6'd21, 1'b0});
    vecs.push_back('{30'd86,         21'd2,       6'd0,  1'b0});
    vecs.push_back('{30'd90177514,   21'd2097151, 6'd21, 1'b0});
`ifdef DIV43_ROUND_EN
    vecs.push_back('{30'd65,         21'd2,       6'd22, 1'b0});
    vecs.push_back('{30'd90177515,   21'd0,       6'd22, 1'b1});
`else
    vecs.push_back('{30'd65,         21'd1,       6'd22, 1'b0});
    vecs.push_back('{30'd90177515,   21'd2097151, 6'd22, 1'b0});
`endif
    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result must hold and new requests must be ignored.
    send(30'd430);
    wait_done(lat);
    chk("bp_latency", 32'(lat), 32'd30);
    for (int i = 0; i < 10; i++) begin
      x_in     = 30'(1000 + i);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_q_out", 32'(q_out), 32'd10);
      chk("bp_r_out", 32'(r_out), 32'd0);
    end
    in_valid = 1'b0;
    handshake();

    // Reset in the middle of BUSY; q_out holds 10 from the previous result.
    send(30'd1000);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_q_out", 32'(q_out), 32'd0);
    chk("mid_rst_r_out", 32'(r_out), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{30'd86, 21'd2, 6'd0, 1'b0});

    // Randomized back-to-back against the arithmetic model.
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      xr = 30'($urandom_range(0, 32'h3FFF_FFFF));
      if (i % 4 == 0) xr = 30'($urandom_range(0, 5000));
      model(xr, qe, re, oe);
      send(xr);
      wait_done(lat);
      chk("rnd_latency", 32'(lat), 32'd30);
      chk("rnd_q_out", 32'(q_out), 32'(qe));
      chk("rnd_r_out", 32'(r_out), 32'(re));
      chk("rnd_ovf", 32'(ovf), 32'(oe));
`ifndef DIV43_ROUND_EN
      if (!ovf) chk("rnd_identity", 32'(q_out) * 32'd43 + 32'(r_out), 32'(xr));
`endif
      @(posedge clk); #1;
    end
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
